// File: rtl/execute_div_arbiter.sv
// execute_div_arbiter: shares one iterative divide engine between two requesters.
// Port 0 is the integer execute stage and port 1 is the microcode/FPU assist path.
// The block accepts one operation at a time and grants round-robin when both ports
// are valid. Zero divisors are answered directly, without using the engine.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   reqN_valid/ready/cmd/size/...     request channel of port N (N = 0, 1)
//   reqN_flush                        cancel port N's in-flight op or pending response
//   rspN_valid/ack/quotient/...       result channel of port N
//   div_start/abort/cmd/size/...      engine command side (all registered)
//   div_done/exception/quotient/...   engine result side (qualified by div_done)
module execute_div_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_cmd,
    input  logic [1:0]  req0_size,
    input  logic [63:0] req0_numer,
    input  logic [31:0] req0_denom,
    input  logic        req0_flush,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_cmd,
    input  logic [1:0]  req1_size,
    input  logic [63:0] req1_numer,
    input  logic [31:0] req1_denom,
    input  logic        req1_flush,
    output logic        rsp0_valid,
    input  logic        rsp0_ack,
    output logic [31:0] rsp0_quotient,
    output logic [31:0] rsp0_remainder,
    output logic [1:0]  rsp0_exception,
    output logic        rsp1_valid,
    input  logic        rsp1_ack,
    output logic [31:0] rsp1_quotient,
    output logic [31:0] rsp1_remainder,
    output logic [1:0]  rsp1_exception,
    output logic        div_start,
    output logic        div_abort,
    output logic [1:0]  div_cmd,
    output logic [1:0]  div_size,
    output logic [63:0] div_numer,
    output logic [31:0] div_denom,
    input  logic        div_done,
    input  logic        div_exception,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder
);

    localparam int unsigned DW = 32;
    localparam int unsigned NW = 64;

    localparam logic [1:0] EXC_NONE = 2'b00;
    localparam logic [1:0] EXC_DZ   = 2'b01;
    localparam logic [1:0] EXC_OVF  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic            own_q, own_d;
    logic            rr_q, rr_d;
    logic [1:0]      cmd_d, size_d;
    logic [NW-1:0]   numer_d;
    logic [DW-1:0]   denom_d;
    logic [DW-1:0]   quot_q, quot_d;
    logic [DW-1:0]   rem_q, rem_d;
    logic [1:0]      exc_q, exc_d;
    logic            start_d, abort_d;
    logic            ready_d, rsp0_valid_d, rsp1_valid_d;

    // Grant selection and operand mux for the IDLE cycle
    logic            any_valid, gnt;
    logic [1:0]      sel_cmd, sel_size, cmd_norm, size_norm;
    logic [NW-1:0]   sel_numer;
    logic [DW-1:0]   sel_denom;
    logic            denom_zero;
    logic            owner_flush, owner_ack;

    assign any_valid = req0_valid | req1_valid;
    assign gnt       = (req0_valid & req1_valid) ? rr_q : req1_valid;
    assign sel_cmd   = gnt ? req1_cmd   : req0_cmd;
    assign sel_size  = gnt ? req1_size  : req0_size;
    assign sel_numer = gnt ? req1_numer : req0_numer;
    assign sel_denom = gnt ? req1_denom : req0_denom;

    // Reserved encodings are folded so the engine only ever sees legal values
    assign cmd_norm  = (sel_cmd  == 2'b11) ? 2'b00 : sel_cmd;
    assign size_norm = (sel_size == 2'b11) ? 2'b10 : sel_size;

    // Zero screen only looks at the divisor bits the operand size uses
    always_comb begin
        denom_zero = 1'b0;
        case (size_norm)
            2'b00:   denom_zero = (sel_denom[7:0]  == 8'd0);
            2'b01:   denom_zero = (sel_denom[15:0] == 16'd0);
            default: denom_zero = (sel_denom == '0);
        endcase
    end

    assign owner_flush = own_q ? req1_flush : req0_flush;
    assign owner_ack   = own_q ? rsp1_ack   : rsp0_ack;

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        rr_d    = rr_q;
        cmd_d   = div_cmd;
        size_d  = div_size;
        numer_d = div_numer;
        denom_d = div_denom;
        quot_d  = quot_q;
        rem_d   = rem_q;
        exc_d   = exc_q;
        start_d = 1'b0;
        abort_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    own_d   = gnt;
                    rr_d    = ~gnt;
                    cmd_d   = cmd_norm;
                    size_d  = size_norm;
                    numer_d = sel_numer;
                    denom_d = sel_denom;
                    if (denom_zero) begin
                        state_d = S_RESP;
                        quot_d  = '0;
                        rem_d   = '0;
                        exc_d   = EXC_DZ;
                    end else begin
                        state_d = S_ISSUE;
                        start_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (owner_flush) begin
                    state_d = S_IDLE;
                    abort_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Flush takes priority over a coincident done; the result is dropped
                if (owner_flush) begin
                    state_d = S_IDLE;
                    abort_d = 1'b1;
                end else if (div_done) begin
                    state_d = S_RESP;
                    quot_d  = div_quotient;
                    rem_d   = div_remainder;
                    exc_d   = div_exception ? EXC_OVF : EXC_NONE;
                end
            end
            S_RESP: begin
                if (owner_ack || owner_flush) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ready_d      = (state_d == S_IDLE);
    assign rsp0_valid_d = (state_d == S_RESP) && !own_d;
    assign rsp1_valid_d = (state_d == S_RESP) &&  own_d;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            own_q      <= 1'b0;
            rr_q       <= 1'b0;
            div_cmd    <= '0;
            div_size   <= '0;
            div_numer  <= '0;
            div_denom  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            exc_q      <= '0;
            div_start  <= 1'b0;
            div_abort  <= 1'b0;
            req0_ready <= 1'b1;
            req1_ready <= 1'b1;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            own_q      <= own_d;
            rr_q       <= rr_d;
            div_cmd    <= cmd_d;
            div_size   <= size_d;
            div_numer  <= numer_d;
            div_denom  <= denom_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            exc_q      <= exc_d;
            div_start  <= start_d;
            div_abort  <= abort_d;
            req0_ready <= ready_d;
            req1_ready <= ready_d;
            rsp0_valid <= rsp0_valid_d;
            rsp1_valid <= rsp1_valid_d;
        end
    end

    // Both ports read the single result register; rspN_valid says who owns it
    assign rsp0_quotient  = quot_q;
    assign rsp0_remainder = rem_q;
    assign rsp0_exception = exc_q;
    assign rsp1_quotient  = quot_q;
    assign rsp1_remainder = rem_q;
    assign rsp1_exception = exc_q;

endmodule

// File: doc/execute_div_arbiter.md
# execute_div_arbiter

Shares one iterative divide engine between two requesters: port 0 is the integer execute stage (DIV/IDIV/AAM) and port 1 is the microcode/FPU assist path. The block captures operands, grants the engine round-robin and sequences the engine's start/abort. It screens zero divisors without using the engine and returns each result, tagged with an exception code, to the requester that owns it. It sits between the execute pipeline and the divide engine.

## Interface
- No parameters.
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- reqN_valid  in  1  request from port N (N = 0, 1)
- reqN_ready  out  1  port N may issue; acceptance = valid & ready
- reqN_cmd  in  2  00 DIV, 01 IDIV, 10 AAM; 11 is reserved and treated as DIV
- reqN_size  in  2  00 8-bit, 01 16-bit, 10 32-bit; 11 is treated as 32-bit
- reqN_numer  in  64  dividend (EDX:EAX form)
- reqN_denom  in  32  divisor
- reqN_flush  in  1  cancel port N's in-flight operation or pending response
- rspN_valid  out  1  result for port N is held
- rspN_ack  in  1  port N consumes the result
- rspN_quotient, rspN_remainder  out  32 each  result
- rspN_exception  out  2  00 none, 01 divide-by-zero, 10 overflow / min-int
- div_start  out  1  one-cycle engine start pulse
- div_abort  out  1  one-cycle engine abort pulse
- div_cmd, div_size  out  2 each  registered copies of the captured command and size
- div_numer  out  64  registered copy of the captured dividend
- div_denom  out  32  registered copy of the captured divisor
- div_done  in  1  engine finished (one-cycle pulse)
- div_exception  in  1  engine overflow / min-int, qualified by div_done
- div_quotient, div_remainder  in  32 each  engine results, qualified by div_done

## Operation
- State machine: IDLE, ISSUE, WAIT, RESP. Owner register `own` (1 bit); round-robin pointer `rr` (1 bit, reset 0).
- IDLE
  - reqN_ready = 1 for both ports; all ready outputs are 0 in every other state.
  - Grant when both ports are valid: the port equal to rr. When one port is valid: that port.
  - On grant: capture cmd, size, numer and denom; set own = granted port; set rr = ~granted port.
- Zero check at grant (8-bit uses denom[7:0], 16-bit uses [15:0], 32-bit uses all 32 bits)
  - Zero divisor: go directly to RESP with exception 01 and quotient = remainder = 0.
  - Otherwise: go to ISSUE.
- ISSUE: assert div_start for exactly one cycle, then go to WAIT.
- WAIT
  - Hold until div_done.
  - On div_done: latch quotient, remainder and exception (10 if div_exception, else 00); go to RESP.
- RESP
  - rsp[own]_valid = 1; outputs stay stable until rsp[own]_ack.
  - On ack: return to IDLE.
- Flush of the owner port
  - In ISSUE or WAIT: pulse div_abort for one cycle, discard the result, go to IDLE. No response is generated.
  - In RESP: drop the response and go to IDLE.
  - Flush of a non-owner port has no effect.
- Simultaneous events
  - div_done together with an owner flush: the flush wins and the result is discarded.
  - ack together with flush in RESP: go to IDLE; the two are equivalent.
  - Owner flush in the grant cycle: ignored, because ownership starts the following cycle.
- Engine contract: a div_done that arrives outside WAIT is ignored.

## Timing
- Reset values: every output is 0 except reqN_ready = 1 (state IDLE); rr = 0.
- Accept at cycle T:
  - div_start is high at T+1.
  - The earliest rsp_valid is the cycle after div_done.
  - Zero divisor: rsp_valid is high at T+1.
- Total latency = engine cycles + 2; single-cycle engine minimum = 3 cycles.
- Back-to-back operation: ack at cycle A means ready is high at A+1. Throughput is one operation per engine latency + 3 cycles.
- div_abort and div_start are never high in the same cycle.
- Reset asserted mid-operation: the FSM goes asynchronously to IDLE with all pulses cleared. The engine is reset by the same rst_n.

## Test plan
- Port 0 only, DIV, 32-bit, numer = 0x0000_0000_0000_0064, denom = 7; engine done after 34 cycles with quotient 14, remainder 2 -> div_start at T+1; rsp0_valid with 14/2, exception 00; ready returns the cycle after ack.
- Both ports valid in IDLE twice in a row after reset -> first grant port 0, second grant port 1; rsp1 is never asserted while rsp0 is pending.
- Port 1, IDIV, 16-bit, denom = 0 -> no div_start; rsp1_valid at T+1 with exception 01 and quotient = remainder = 0.
- Engine returns div_exception = 1 for port 0 IDIV 8-bit -> rsp0_exception = 10.
- Flush port 0 during WAIT, with div_done asserted in the same cycle -> div_abort pulse, no rsp0_valid, ready = 1 the next cycle.
- rst_n dropped during WAIT -> all outputs at reset values immediately; a new request after reset is accepted and is granted to port 0 when both ports are valid.
